// File: rtl/onchip_mem_arbiter_pkg.sv
// onchip_mem_arbiter_pkg: shared types and constants for the two-master RAM arbiter.
package onchip_mem_arbiter_pkg;
    typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} lock_state_t;
    localparam bit M0 = 1'b0;
    localparam bit M1 = 1'b1;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// onchip_mem_arbiter_if: one master's command/response bus into the arbiter.
interface onchip_mem_arbiter_if
    import onchip_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                lock;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    modport master (
        output address, byteenable, read, write, writedata, lock,
        input  waitrequest, readdata, readdatavalid
    );
    modport slave (
        input  address, byteenable, read, write, writedata, lock,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// rr_arb2: two-way grant generator, round-robin on last_grant or master 0 fixed priority.
module rr_arb2
    import onchip_mem_arbiter_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_grant;
    // Master 0 wins a conflict when master 1 had the previous grant.
    assign gnt[M0] = req[M0] & (~req[M1] | FIXED_PRIO | last_grant);
    assign gnt[M1] = req[M1] & ~gnt[M0];
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            last_grant <= M1;
        else if (|gnt)
            last_grant <= gnt[M1];
endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: shares one single-port RAM between two masters with lock
// and a one-cycle read-return pipeline steered back to the issuer.
module onchip_mem_arbiter
    import onchip_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    onchip_mem_arbiter_if.slave   m0,
    onchip_mem_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    input  logic [DATA_W-1:0]     mem_readdata
);
    lock_state_t lock_q, lock_d;
    logic [1:0]  req, req_ok, gnt;
    logic        acc_rd, rd_vld_q, rd_own_q;
    assign req = {m1.read | m1.write, m0.read | m0.write};
    // Requests are masked while in reset so nothing reaches the RAM.
    assign req_ok = reset_n ? req & (lock_q == LOCKED0 ? 2'b01 : lock_q == LOCKED1 ? 2'b10 : 2'b11) : 2'b00;
    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_ok),
        .gnt     (gnt)
    );
    always_comb begin
        mem_chipselect = |gnt;
        mem_address    = gnt[M1] ? m1.address    : gnt[M0] ? m0.address    : '0;
        mem_byteenable = gnt[M1] ? m1.byteenable : gnt[M0] ? m0.byteenable : '0;
        mem_writedata  = gnt[M1] ? m1.writedata  : gnt[M0] ? m0.writedata  : '0;
        mem_write      = gnt[M1] ? m1.write      : gnt[M0] & m0.write;
        acc_rd         = gnt[M1] ? m1.read & ~m1.write : gnt[M0] & m0.read & ~m0.write;
        lock_d         = gnt[M1] ? (m1.lock ? LOCKED1 : UNLOCKED)
                       : gnt[M0] ? (m0.lock ? LOCKED0 : UNLOCKED) : lock_q;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            lock_q   <= UNLOCKED;
            rd_vld_q <= 1'b0;
            rd_own_q <= M0;
        end else begin
            lock_q   <= lock_d;
            rd_vld_q <= acc_rd;
            if (acc_rd)
                rd_own_q <= gnt[M1];
        end
    assign m0.waitrequest   = ~gnt[M0];
    assign m1.waitrequest   = ~gnt[M1];
    assign m0.readdatavalid = rd_vld_q & (rd_own_q == M0);
    assign m1.readdatavalid = rd_vld_q & (rd_own_q == M1);
    assign m0.readdata      = m0.readdatavalid ? mem_readdata : '0;
    assign m1.readdata      = m1.readdatavalid ? mem_readdata : '0;
endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the RAM word-address width (1024 words).
REQ-002 SHALL have parameter DATA_W, default 32, giving the data width; byteenable width is DATA_W/8.
REQ-003 SHALL have parameter FIXED_PRIO, default 0; 0 selects round-robin arbitration, 1 makes master 0 always win.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-006 SHALL have, for each master i in {0,1}, these ports:
- mi_address, input, ADDR_W, word address.
- mi_byteenable, input, DATA_W/8, byte lanes.
- mi_read, input, 1, read request.
- mi_write, input, 1, write request.
- mi_writedata, input, DATA_W, write data.
- mi_lock, input, 1, holds the grant after this command.
- mi_waitrequest, output, 1, command not accepted this cycle.
- mi_readdata, output, DATA_W, returned read data.
- mi_readdatavalid, output, 1, mi_readdata is valid.
REQ-007 SHALL have these RAM-side ports:
- mem_address, output, ADDR_W.
- mem_byteenable, output, DATA_W/8.
- mem_chipselect, output, 1.
- mem_write, output, 1.
- mem_writedata, output, DATA_W.
- mem_readdata, input, DATA_W; the RAM registers the address and does not register its output.

Function
REQ-008 SHALL treat master i as requesting when mi_read or mi_write is high; asserting read and write together SHALL be treated as a write.
REQ-009 SHALL grant at most one master per cycle, combinationally from the current requests, the lock state and the priority state.
REQ-010 SHALL drive the granted master's waitrequest low; every other requesting master SHALL see waitrequest high, and a non-requesting master's waitrequest SHALL be high.
REQ-011 SHALL drive mem_chipselect high and pass the granted master's address, byteenable, writedata and write straight through in the grant cycle, with zero added latency.
REQ-012 SHALL hold mem_chipselect and mem_write low and mem_address/mem_byteenable/mem_writedata at 0 when no master is granted.
REQ-013 Round-robin (FIXED_PRIO=0): SHALL keep a 1-bit last_grant register; when both masters request, the master not equal to last_grant wins; last_grant SHALL update only on an accepted command.
REQ-014 Fixed priority (FIXED_PRIO=1): master 0 SHALL always win a conflict, and last_grant SHALL be ignored.
REQ-015 Read return: an accepted read in cycle N SHALL return mem_readdata on the owner's readdata with readdatavalid high for exactly cycle N+1, using a registered 1-bit return tag.
REQ-016 A non-owner's readdatavalid SHALL be low and its readdata 0.
REQ-017 Back-to-back reads from alternating masters SHALL sustain one accepted command per cycle, with each return steered to its issuer.
REQ-018 Lock state machine, two states:
- UNLOCKED to LOCKED(i) when master i has an accepted command with mi_lock=1.
- LOCKED(i) to UNLOCKED when master i has an accepted command with mi_lock=0.
REQ-019 In LOCKED(i), SHALL grant only master i; the other master's waitrequest SHALL stay high even if master i is idle.
REQ-020 A write accepted in cycle N SHALL produce no readdatavalid, and a read of the same address in cycle N+1 SHALL return the new data.

Reset
REQ-021 While reset_n is low, SHALL force:
- last_grant = 1, so master 0 wins the first conflict.
- Lock state = UNLOCKED.
- Return tag valid = 0.
- Both waitrequests = 1, both readdatavalids = 0.
- mem_chipselect = 0, mem_write = 0.
REQ-022 Reset asserted mid-operation SHALL discard any pending read return; no readdatavalid SHALL be emitted for a command accepted in the cycle reset asserts.
REQ-023 After reset_n deasserts, SHALL accept commands from the first following clk edge.

Structure
REQ-024 A shared package SHALL hold:
- The lock-state enum (UNLOCKED, LOCKED0, LOCKED1).
- Master-index constants M0=0 and M1=1.
- The default ADDR_W and DATA_W.
REQ-025 SHALL contain one sub-module, rr_arb2, a 2-way round-robin grant generator with a last_grant register and fixed-priority override; the lock and return pipeline SHALL stay at top level.

Verification
REQ-026 Reset, then m0 writes 0xDEADBEEF to address 0x005 with byteenable 0xF, then m0 reads 0x005 -> m0_readdatavalid high exactly one cycle after the read is accepted, with m0_readdata = 0xDEADBEEF.
REQ-027 Both masters read continuously (m0 at 0x010, m1 at 0x020) under FIXED_PRIO=0 -> grants alternate m0, m1, m0, and so on; each readdatavalid carries the correct word; one command is accepted per cycle.
REQ-028 Same stimulus with FIXED_PRIO=1 -> m1_waitrequest stays high throughout and m0 is granted every cycle.
REQ-029 m1 reads 0x3FF with m1_lock=1, then idles 3 cycles while m0 requests, then reads with m1_lock=0 -> m0 stays waited for 4 cycles and is granted in the cycle after m1's unlocking read.
REQ-030 m0 writes byteenable 0x3 of 0x12345678 over 0xFFFFFFFF at 0x100, then reads 0x100 -> 0xFFFF5678.
REQ-031 reset_n pulsed low in the cycle after an accepted m0 read -> no m0_readdatavalid is emitted, all waitrequests are high during reset, and m0 wins the first conflict after reset.
